ecc_scalar_mult_ctrl: RTL and testbench



---
 rtl/ecc_scalar_mult_ctrl_pkg.sv | 13 +
 rtl/ECCDefine.vh | 6 +
 rtl/ecc_scalar_mult_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ecc_scalar_mult_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scalar_mult_ctrl_pkg.sv
// rtl/ecc_scalar_mult_ctrl_pkg.sv - state encoding for the double-and-add controller
`include "ECCDefine.vh"
package ecc_scalar_mult_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DBL      = 3'd1,
      S_DBL_WAIT = 3'd2,
      S_ADD      = 3'd3,
      S_ADD_WAIT = 3'd4,
      S_STEP     = 3'd5,
      S_DONE     = 3'd6
   } state_t;
endpackage

// File: rtl/ECCDefine.vh
// rtl/ECCDefine.vh - default ECC operand width and the point-at-infinity x encoding
`ifndef ECC_DEFINE_VH
`define ECC_DEFINE_VH
`define MAX_BITS 256
`define ECC_INF_X '1
`endif

// File: rtl/ecc_scalar_mult_ctrl.sv
// rtl/ecc_scalar_mult_ctrl.sv - MSB-first double-and-add controller driving external point engines
// Optional ECC_CONST_TIME_EN: one double and one add request per scalar bit, dummies discarded.
`include "ECCDefine.vh"
module ecc_scalar_mult_ctrl
   import ecc_scalar_mult_ctrl_pkg::*;
#(
   parameter int W     = `MAX_BITS,
   parameter int IDX_W = 9
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_k,
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_y,
   input  logic [W-1:0] i_p,
   output logic         o_busy,
   output logic         o_finished,
   output logic [W-1:0] o_result_x,
   output logic [W-1:0] o_result_y,
   output logic         o_dbl_start,
   output logic [W-1:0] o_dbl_x,
   output logic [W-1:0] o_dbl_y,
   input  logic         i_dbl_finish,
   input  logic [W-1:0] i_dbl_rx,
   input  logic [W-1:0] i_dbl_ry,
   output logic         o_add_start,
   output logic [W-1:0] o_add_x1,
   output logic [W-1:0] o_add_y1,
   output logic [W-1:0] o_add_x2,
   output logic [W-1:0] o_add_y2,
   input  logic         i_add_finish,
   input  logic [W-1:0] i_add_rx,
   input  logic [W-1:0] i_add_ry
);
   state_t           state, state_n;
   logic [W-1:0]     k_r, k_n, px, px_n, py, py_n, pp, pp_n;
   logic [W-1:0]     acc_x, acc_x_n, acc_y, acc_y_n;
   logic [W-1:0]     res_x, res_x_n, res_y, res_y_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             dbl_start, dbl_start_n, add_start, add_start_n;
   logic [W-1:0]     dbl_x, dbl_x_n, dbl_y, dbl_y_n;
   logic [W-1:0]     add_x1, add_x1_n, add_y1, add_y1_n, add_x2, add_x2_n, add_y2, add_y2_n;
   logic             dbl_to_step, dbl_to_step_n;
`ifdef ECC_CONST_TIME_EN
   logic             keep, keep_n;
   logic [W-1:0]     t2_x, t2_x_n, t2_y, t2_y_n;
   logic             t2_v, t2_v_n;
`endif

   logic [W-1:0] k_sh, neg_py;
   logic         acc_inf, bit_set, eq_x, eq_y, neg_y;

   assign k_sh    = k_r >> idx;
   assign bit_set = k_sh[0];
   assign neg_py  = pp - py;
   assign acc_inf = (acc_x == `ECC_INF_X);
   assign eq_x    = (acc_x == px);
   assign eq_y    = (acc_y == py);
   assign neg_y   = (acc_y == neg_py);

   assign o_busy      = (state != S_IDLE);
   assign o_finished  = (state == S_DONE);
   assign o_result_x  = res_x;
   assign o_result_y  = res_y;
   assign o_dbl_start = dbl_start;
   assign o_dbl_x     = dbl_x;
   assign o_dbl_y     = dbl_y;
   assign o_add_start = add_start;
   assign o_add_x1    = add_x1;
   assign o_add_y1    = add_y1;
   assign o_add_x2    = add_x2;
   assign o_add_y2    = add_y2;

   always_comb begin
      state_n = state;  k_n = k_r;  px_n = px;  py_n = py;  pp_n = pp;
      acc_x_n = acc_x;  acc_y_n = acc_y;  res_x_n = res_x;  res_y_n = res_y;
      idx_n = idx;  dbl_start_n = 1'b0;  add_start_n = 1'b0;
      dbl_x_n = dbl_x;  dbl_y_n = dbl_y;
      add_x1_n = add_x1;  add_y1_n = add_y1;  add_x2_n = add_x2;  add_y2_n = add_y2;
      dbl_to_step_n = dbl_to_step;
`ifdef ECC_CONST_TIME_EN
      keep_n = keep;  t2_x_n = t2_x;  t2_y_n = t2_y;  t2_v_n = t2_v;
`endif
      case (state)
         S_IDLE: if (i_start) begin
            k_n = i_k;  px_n = i_x;  py_n = i_y;  pp_n = i_p;
            acc_x_n = `ECC_INF_X;  acc_y_n = '0;
            idx_n = IDX_W'(W - 1);
`ifdef ECC_CONST_TIME_EN
            t2_v_n = 1'b0;
`endif
            if (i_k == '0) begin
               res_x_n = `ECC_INF_X;  res_y_n = '0;  state_n = S_DONE;
            end else begin
               state_n = S_DBL;
            end
         end
         S_DBL: begin
`ifdef ECC_CONST_TIME_EN
            // Doubling infinity is replaced by a discarded double of P, which yields 2P for the dummy adds.
            dbl_start_n = 1'b1;  dbl_to_step_n = 1'b0;  keep_n = !acc_inf;
            dbl_x_n = acc_inf ? px : acc_x;
            dbl_y_n = acc_inf ? py : acc_y;
            state_n = S_DBL_WAIT;
`else
            if (acc_inf) begin
               state_n = S_ADD;
            end else begin
               dbl_start_n = 1'b1;  dbl_to_step_n = 1'b0;
               dbl_x_n = acc_x;  dbl_y_n = acc_y;
               state_n = S_DBL_WAIT;
            end
`endif
         end
         S_DBL_WAIT: if (i_dbl_finish && !dbl_start) begin
`ifdef ECC_CONST_TIME_EN
            if (keep) begin
               acc_x_n = i_dbl_rx;  acc_y_n = i_dbl_ry;
            end else if (!t2_v) begin
               t2_x_n = i_dbl_rx;  t2_y_n = i_dbl_ry;  t2_v_n = 1'b1;
            end
`else
            acc_x_n = i_dbl_rx;  acc_y_n = i_dbl_ry;
`endif
            state_n = dbl_to_step ? S_STEP : S_ADD;
         end
         S_ADD: begin
`ifdef ECC_CONST_TIME_EN
            add_start_n = 1'b1;  keep_n = 1'b0;  state_n = S_ADD_WAIT;
            add_x1_n = px;  add_y1_n = py;
            add_x2_n = t2_v ? t2_x : px;
            add_y2_n = t2_v ? t2_y : py;
            if (bit_set) begin
               if (acc_inf) begin
                  acc_x_n = px;  acc_y_n = py;
               end else if (eq_x && eq_y) begin
                  acc_x_n = t2_x;  acc_y_n = t2_y;
               end else if (eq_x && neg_y) begin
                  acc_x_n = `ECC_INF_X;  acc_y_n = '0;
               end else begin
                  keep_n = 1'b1;
                  add_x1_n = acc_x;  add_y1_n = acc_y;  add_x2_n = px;  add_y2_n = py;
               end
            end
`else
            state_n = S_STEP;
            if (bit_set) begin
               if (acc_inf) begin
                  acc_x_n = px;  acc_y_n = py;
               end else if (eq_x && eq_y) begin
                  // The adder cannot do P+P; route it to the doubler and resume at STEP.
                  dbl_start_n = 1'b1;  dbl_to_step_n = 1'b1;
                  dbl_x_n = px;  dbl_y_n = py;
                  state_n = S_DBL_WAIT;
               end else if (eq_x && neg_y) begin
                  acc_x_n = `ECC_INF_X;  acc_y_n = '0;
               end else begin
                  add_start_n = 1'b1;
                  add_x1_n = acc_x;  add_y1_n = acc_y;  add_x2_n = px;  add_y2_n = py;
                  state_n = S_ADD_WAIT;
               end
            end
`endif
         end
         S_ADD_WAIT: if (i_add_finish && !add_start) begin
`ifdef ECC_CONST_TIME_EN
            if (keep) begin
               acc_x_n = i_add_rx;  acc_y_n = i_add_ry;
            end
`else
            acc_x_n = i_add_rx;  acc_y_n = i_add_ry;
`endif
            state_n = S_STEP;
         end
         S_STEP: begin
            if (idx == '0) begin
               res_x_n = acc_x;  res_y_n = acc_y;  state_n = S_DONE;
            end else begin
               idx_n = idx - IDX_W'(1);  state_n = S_DBL;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;  k_r <= '0;  px <= '0;  py <= '0;  pp <= '0;
         acc_x <= `ECC_INF_X;  acc_y <= '0;  res_x <= '0;  res_y <= '0;
         idx <= '0;  dbl_start <= 1'b0;  add_start <= 1'b0;
         dbl_x <= '0;  dbl_y <= '0;
         add_x1 <= '0;  add_y1 <= '0;  add_x2 <= '0;  add_y2 <= '0;
         dbl_to_step <= 1'b0;
`ifdef ECC_CONST_TIME_EN
         keep <= 1'b0;  t2_x <= '0;  t2_y <= '0;  t2_v <= 1'b0;
`endif
      end else begin
         state <= state_n;  k_r <= k_n;  px <= px_n;  py <= py_n;  pp <= pp_n;
         acc_x <= acc_x_n;  acc_y <= acc_y_n;  res_x <= res_x_n;  res_y <= res_y_n;
         idx <= idx_n;  dbl_start <= dbl_start_n;  add_start <= add_start_n;
         dbl_x <= dbl_x_n;  dbl_y <= dbl_y_n;
         add_x1 <= add_x1_n;  add_y1 <= add_y1_n;  add_x2 <= add_x2_n;  add_y2 <= add_y2_n;
         dbl_to_step <= dbl_to_step_n;
`ifdef ECC_CONST_TIME_EN
         keep <= keep_n;  t2_x <= t2_x_n;  t2_y <= t2_y_n;  t2_v <= t2_v_n;
`endif
      end
   end
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// tb/tb_ecc_scalar_mult_ctrl.sv - self-checking bench for ecc_scalar_mult_ctrl with stub point engines
module tb_ecc_scalar_mult_ctrl;
   localparam int W     = 8;
   localparam int IDX_W = 4;
   localparam logic [W-1:0] PX  = 8'd5;
   localparam logic [W-1:0] PY  = 8'd1;
   localparam logic [W-1:0] PP  = 8'd11;
   localparam logic [W-1:0] INF = 8'hFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_start;
   logic [W-1:0] i_k, i_x, i_y, i_p;
   logic         o_busy, o_finished;
   logic [W-1:0] o_result_x, o_result_y;
   logic         o_dbl_start;
   logic [W-1:0] o_dbl_x, o_dbl_y;
   logic         i_dbl_finish;
   logic [W-1:0] i_dbl_rx, i_dbl_ry;
   logic         o_add_start;
   logic [W-1:0] o_add_x1, o_add_y1, o_add_x2, o_add_y2;
   logic         i_add_finish;
   logic [W-1:0] i_add_rx, i_add_ry;

   always #5 clk = ~clk;

   ecc_scalar_mult_ctrl #(.W(W), .IDX_W(IDX_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_k(i_k), .i_x(i_x), .i_y(i_y), .i_p(i_p),
      .o_busy(o_busy), .o_finished(o_finished), .o_result_x(o_result_x), .o_result_y(o_result_y),
      .o_dbl_start(o_dbl_start), .o_dbl_x(o_dbl_x), .o_dbl_y(o_dbl_y),
      .i_dbl_finish(i_dbl_finish), .i_dbl_rx(i_dbl_rx), .i_dbl_ry(i_dbl_ry),
      .o_add_start(o_add_start), .o_add_x1(o_add_x1), .o_add_y1(o_add_y1),
      .o_add_x2(o_add_x2), .o_add_y2(o_add_y2),
      .i_add_finish(i_add_finish), .i_add_rx(i_add_rx), .i_add_ry(i_add_ry)
   );

   int tests_run = 0;
   int failed    = 0;
   int dbl_lat   = 1;
   int add_lat   = 1;
   int stray_req = 0;
   logic [W-1:0] stub_dbl_rx = 8'd9, stub_dbl_ry = 8'd9;
   logic [W-1:0] stub_add_rx = 8'd7, stub_add_ry = 8'd7;

   logic [2*W-1:0] dbl_obs[$];
   logic [4*W-1:0] add_obs[$];
   logic [2*W-1:0] dbl_exp_q[$];
   logic [4*W-1:0] add_exp_q[$];
   logic [2*W-1:0] res_q[$];

   // Doubler stub: records each request, answers dbl_lat cycles later; also emits requested stray finishes.
   initial begin : dbl_stub
      int stray_seen;
      stray_seen = 0;
      i_dbl_finish = 1'b0;  i_dbl_rx = '0;  i_dbl_ry = '0;
      forever begin
         @(negedge clk);
         if (o_dbl_start) begin
            dbl_obs.push_back({o_dbl_x, o_dbl_y});
            repeat (dbl_lat) @(negedge clk);
            i_dbl_rx = stub_dbl_rx;  i_dbl_ry = stub_dbl_ry;  i_dbl_finish = 1'b1;
            @(negedge clk);
            i_dbl_finish = 1'b0;
         end else if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            i_dbl_rx = 8'h33;  i_dbl_ry = 8'h44;  i_dbl_finish = 1'b1;
            @(negedge clk);
            i_dbl_finish = 1'b0;
         end
      end
   end

   initial begin : add_stub
      i_add_finish = 1'b0;  i_add_rx = '0;  i_add_ry = '0;
      forever begin
         @(negedge clk);
         if (o_add_start) begin
            add_obs.push_back({o_add_x1, o_add_y1, o_add_x2, o_add_y2});
            repeat (add_lat) @(negedge clk);
            i_add_rx = stub_add_rx;  i_add_ry = stub_add_ry;  i_add_finish = 1'b1;
            @(negedge clk);
            i_add_finish = 1'b0;
         end
      end
   end

   task automatic run_op(input string name, input logic [W-1:0] k, input int exp_lat,
                         input int exp_dbl, input int exp_add, input bit glitch);
      int b_dbl, b_add, lat, i;
      logic [2*W-1:0] e2;
      logic [4*W-1:0] e4;
      b_dbl = dbl_obs.size();
      b_add = add_obs.size();
      @(negedge clk);
      i_k = k;  i_x = PX;  i_y = PY;  i_p = PP;  i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;  lat = 1;
      tests_run++;
      if (o_busy !== 1'b1) begin
         failed++;  $display("FAIL %s_busy: got %b required 1", name, o_busy);
      end
      while (!o_finished && lat < 2000) begin
         @(negedge clk);
         lat++;
         if (glitch) begin
            i_start = (lat >= 3 && lat <= 5);
            i_k = 8'd0;
         end
      end
      i_start = 1'b0;
      tests_run++;
      if (o_finished !== 1'b1) begin
         failed++;  $display("FAIL %s_timeout: o_finished=%b after %0d cycles", name, o_finished, lat);
      end else begin
         e2 = res_q.pop_front();
         if ({o_result_x, o_result_y} !== e2) begin
            failed++;  $display("FAIL %s_result: got %h required %h", name, {o_result_x, o_result_y}, e2);
         end
         if (exp_lat >= 0) begin
            tests_run++;
            if (lat != exp_lat) begin
               failed++;  $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
            end
         end
      end
      @(negedge clk);
      tests_run++;
      if (dbl_obs.size() - b_dbl != exp_dbl || add_obs.size() - b_add != exp_add) begin
         failed++;
         $display("FAIL %s_requests: got dbl=%0d add=%0d required dbl=%0d add=%0d", name,
                  dbl_obs.size() - b_dbl, add_obs.size() - b_add, exp_dbl, exp_add);
      end
      i = 0;
      while (dbl_exp_q.size() > 0) begin
         e2 = dbl_exp_q.pop_front();
         tests_run++;
         if (b_dbl + i >= dbl_obs.size() || dbl_obs[b_dbl + i] !== e2) begin
            failed++;  $display("FAIL %s_dbl_op%0d: required %h", name, i, e2);
         end
         i++;
      end
      i = 0;
      while (add_exp_q.size() > 0) begin
         e4 = add_exp_q.pop_front();
         tests_run++;
         if (b_add + i >= add_obs.size() || add_obs[b_add + i] !== e4) begin
            failed++;  $display("FAIL %s_add_op%0d: required %h", name, i, e4);
         end
         i++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;  i_start = 1'b0;  i_k = '0;  i_x = '0;  i_y = '0;  i_p = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({o_busy, o_finished, o_dbl_start, o_add_start, o_result_x, o_result_y} !== '0) begin
         failed++;
         $display("FAIL reset_outputs: busy=%b fin=%b dbl=%b add=%b res=%h%h required all 0",
                  o_busy, o_finished, o_dbl_start, o_add_start, o_result_x, o_result_y);
      end
      rst = 1'b0;
   endtask

   task automatic test_k_zero();
      res_q.push_back({INF, 8'd0});
      run_op("k_zero", 8'd0, 1, 0, 0, 1'b0);
   endtask

   task automatic test_k_one();
      res_q.push_back({PX, PY});
      run_op("k_one", 8'd1, 3 * W + 1, 0, 0, 1'b0);
   endtask

   task automatic test_dbl_add();
      stub_dbl_rx = 8'd9;  stub_dbl_ry = 8'd9;  stub_add_rx = 8'd7;  stub_add_ry = 8'd7;
      dbl_exp_q.push_back({PX, PY});
      add_exp_q.push_back({8'd9, 8'd9, PX, PY});
      res_q.push_back({8'd7, 8'd7});
      run_op("dbl_add", 8'd3, 29, 1, 0 + 1, 1'b0);
   endtask

   task automatic test_p_plus_p();
      stub_dbl_rx = PX;  stub_dbl_ry = PY;
      dbl_exp_q.push_back({PX, PY});
      dbl_exp_q.push_back({PX, PY});
      res_q.push_back({PX, PY});
      run_op("p_plus_p", 8'd3, -1, 2, 0, 1'b0);
   endtask

   task automatic test_p_minus_p();
      stub_dbl_rx = PX;  stub_dbl_ry = PP - PY;
      dbl_exp_q.push_back({PX, PY});
      res_q.push_back({INF, 8'd0});
      run_op("p_minus_p", 8'd3, -1, 1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      res_q.push_back({PX, PY});
      run_op("start_while_busy", 8'd1, 3 * W + 1, 0, 0, 1'b1);
      res_q.push_back({INF, 8'd0});
      run_op("back_to_back", 8'd0, 1, 0, 0, 1'b0);
   endtask

   task automatic test_const_time();
      stub_dbl_rx = 8'd9;  stub_dbl_ry = 8'd9;  stub_add_rx = 8'd7;  stub_add_ry = 8'd7;
      for (int i = 0; i < W; i++) begin
         dbl_exp_q.push_back({PX, PY});
         add_exp_q.push_back({PX, PY, 8'd9, 8'd9});
      end
      res_q.push_back({PX, PY});
      run_op("const_time", 8'd1, 7 * W + 1, W, W, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n;
      logic bad;
      stub_dbl_rx = 8'd9;  stub_dbl_ry = 8'd9;  dbl_lat = 4;
      @(negedge clk);
      i_k = 8'd3;  i_x = PX;  i_y = PY;  i_p = PP;  i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;  n = 0;
      while (!o_dbl_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (!o_dbl_start) begin
         failed++;  $display("FAIL reset_mid_no_request: o_dbl_start=%b", o_dbl_start);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if ({o_busy, o_finished, o_dbl_start, o_add_start, o_result_x, o_result_y} !== '0) begin
         failed++;  $display("FAIL reset_mid_async: busy=%b dbl=%b res=%h%h required 0",
                             o_busy, o_dbl_start, o_result_x, o_result_y);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stray_req++;
      bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (o_busy || o_finished || o_dbl_start || o_add_start) bad = 1'b1;
      end
      tests_run++;
      if (bad !== 1'b0) begin
         failed++;  $display("FAIL reset_mid_quiet: activity seen after reset, got %b required 0", bad);
      end
      dbl_lat = 1;
      res_q.push_back({8'd9, 8'd9});
`ifdef ECC_CONST_TIME_EN
      run_op("restart_k2", 8'd2, -1, W, W, 1'b0);
`else
      dbl_exp_q.push_back({PX, PY});
      run_op("restart_k2", 8'd2, -1, 1, 0, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_k_zero();
`ifdef ECC_CONST_TIME_EN
      test_const_time();
`else
      test_k_one();
      test_dbl_add();
      test_p_plus_p();
      test_p_minus_p();
      test_back_to_back();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
